// File: rtl/decision_framer.sv
// Decision framer: buffers {type, payload} records in a small FIFO and
// serialises each one as a UART byte frame: SYNC_BYTE, type, payload bytes
// (most-significant first). Defining DECISION_FRAMER_CKSUM_EN appends an
// XOR checksum byte; without it the checksum state does not exist.
module decision_framer #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dec_valid,
  input  logic [7:0]                    dec_type,
  input  logic [8*DATA_BYTES-1:0]       dec_data,
  output logic                          dec_ready,
  output logic [7:0]                    tx_byte,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt,
  output logic [31:0]                   frame_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned RecW = 8 + 8 * DATA_BYTES;
  localparam int unsigned IdxW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

`ifdef DECISION_FRAMER_CKSUM_EN
  typedef enum logic [2:0] {StIdle, StSync, StType, StData, StCksum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSync, StType, StData} state_e;
`endif

  // ---------------------------------------------------------------------------
  // Record FIFO
  // ---------------------------------------------------------------------------
  logic [RecW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            push, pop, fifo_empty;

  assign fifo_empty = (level_q == '0);
  assign dec_ready  = (level_q != LvlW'(FIFO_DEPTH));
  assign push       = dec_valid & dec_ready;
  assign fifo_level = level_q;

  // Storage array is data-only; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {dec_type, dec_data};
  end

  // Pointer and level bookkeeping; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame serialiser
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [RecW-1:0] shadow_q, shadow_d;
  logic [7:0]      pay [DATA_BYTES];
  logic            frame_done;

  // Split the shadow payload into bytes, index 0 being the most significant.
  always_comb begin
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      pay[i] = shadow_q[8*(DATA_BYTES-1-i) +: 8];
    end
  end

`ifdef DECISION_FRAMER_CKSUM_EN
  logic [7:0] cksum;

  // Checksum covers the type byte and every payload byte.
  always_comb begin
    cksum = shadow_q[RecW-1 -: 8];
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      cksum = cksum ^ pay[i];
    end
  end
`endif

  // Next-state, pop and output decode; the next record is popped on the final
  // handshake so back-to-back frames have no idle cycle between them.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    tx_valid   = (state_q != StIdle);
    tx_byte    = 8'h00;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StSync;
        end
      end
      StSync: begin
        tx_byte = SYNC_BYTE;
        if (tx_ready) state_d = StType;
      end
      StType: begin
        tx_byte = shadow_q[RecW-1 -: 8];
        if (tx_ready) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        tx_byte = pay[idx_q];
        if (tx_ready) begin
          if (idx_q == IdxW'(DATA_BYTES - 1)) begin
`ifdef DECISION_FRAMER_CKSUM_EN
            state_d = StCksum;
`else
            frame_done = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef DECISION_FRAMER_CKSUM_EN
      StCksum: begin
        tx_byte = cksum;
        if (tx_ready) frame_done = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (frame_done) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = StSync;
      end else begin
        state_d = StIdle;
      end
    end

    if (pop) shadow_d = mem_q[rd_ptr_q];
  end

  // FSM, byte index and frame shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [15:0] drop_cnt_q;
  logic [31:0] frame_cnt_q;

  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

  // Refused offers saturate; completed frames wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (dec_valid && !dec_ready && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (frame_done) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

endmodule
